// File: rtl/uart_pkg.sv
// Shared types and constants for the user UART receive peripheral.
//   rx_state_t  : receiver FSM states
//   OFS_*       : register offsets from RX_BASE
//   STAT_*      : bit positions inside the STAT register
//   bit_cycles  : rounded clock cycles per serial bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic [2:0]  OFS_DATA = 3'h0;
  localparam logic [2:0]  OFS_STAT = 3'h4;

  localparam logic [31:0] RX_BASE  = 32'h0003_0004;
  localparam logic [31:0] RX_LAST  = 32'h0003_000B;

  localparam int unsigned STAT_NEMPTY = 0;
  localparam int unsigned STAT_OVR    = 1;
  localparam int unsigned STAT_FERR   = 2;

  // round(clk_hz / baud)
  function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when full with a pop
//   pop        : read request; ignored while empty
//   full/empty : status, count : number of stored entries, head : oldest entry
module sync_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [DW-1:0] head
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  // A pop frees a slot this cycle, so a push while full is still accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array carries no reset; only pointer state defines contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/user_uart_rx.sv
// 8N1 UART receiver with a byte FIFO behind a naive_bus slave port.
//   clk, rst          : system clock, asynchronous active-high reset
//   i_uart_rx         : serial line, idle high, asynchronous to clk
//   rd_req/rd_addr    : read request; rd_gnt same cycle on address hit
//   rd_data           : registered read data, valid the cycle after grant
//   wr_req/wr_addr/wr_be/wr_data : write request; wr_gnt same cycle on hit
// Registers (from 0x0003_0004): +0 DATA (read pops), +4 STAT (flags, count).
module user_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  input  logic        rd_req,
  output logic        rd_gnt,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_req,
  output logic        wr_gnt,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned TW      = $clog2(BIT_CYC);
  localparam logic [TW-1:0] FULL_LOAD = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BIT_CYC / 2 - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  logic [1:0]       sync_q;
  logic             rx_bit;
  rx_state_t        state;
  logic [TW-1:0]    timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push;
  logic             ferr_set;

  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;
  logic [7:0]       head;
  logic             pop;

  logic             overrun;
  logic             ferr;
  logic             ovr_set;

  logic             rd_hit;
  logic             wr_hit;
  logic [2:0]       rd_off;
  logic [2:0]       wr_off;
  logic             rd_is_data;
  logic             stat_wr;
  logic [31:0]      data_word;
  logic [31:0]      stat_word;
  logic             unused_bits;

  // Two-flop synchroniser; resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], i_uart_rx};
  end
  assign rx_bit = sync_q[1];

  // Frame FSM: timer counts down to 0, sampling on the cycle it reads 0.
  // A low level in IDLE counts as a start edge, so a line already low at
  // reset release starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      push     <= 1'b0;
      ferr_set <= 1'b0;
    end else begin
      push     <= 1'b0;
      ferr_set <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_bit) begin
            state <= START;
            timer <= HALF_LOAD;
          end
        end
        START: begin
          if (timer == '0) begin
            if (!rx_bit) begin
              state   <= DATA;
              timer   <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end
        DATA: begin
          if (timer == '0) begin
            shreg <= {rx_bit, shreg[7:1]};
            timer <= FULL_LOAD;
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (rx_bit) begin
              push  <= 1'b1;
              state <= IDLE;
            end else begin
              ferr_set <= 1'b1;
              state    <= BREAK;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end
        BREAK: begin
          if (rx_bit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Address decode over the 8-byte window.
  assign rd_hit     = (rd_addr >= RX_BASE) && (rd_addr <= RX_LAST);
  assign wr_hit     = (wr_addr >= RX_BASE) && (wr_addr <= RX_LAST);
  assign rd_off     = 3'(rd_addr - RX_BASE);
  assign wr_off     = 3'(wr_addr - RX_BASE);
  assign rd_gnt     = rd_req & rd_hit;
  assign wr_gnt     = wr_req & wr_hit;
  assign rd_is_data = (rd_off & OFS_STAT) == OFS_DATA;
  assign stat_wr    = wr_gnt && ((wr_off & OFS_STAT) == OFS_STAT) && wr_be[0];

  assign pop       = rd_gnt & rd_is_data & ~empty;
  assign ovr_set   = push & full & ~pop;
  assign data_word = empty ? 32'h0 : {23'h0, 1'b1, head};
  assign stat_word = {16'h0, 8'(count), 5'h0, ferr, overrun, ~empty};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '0;
    else if (rd_gnt) rd_data <= rd_is_data ? data_word : stat_word;
  end

  // Sticky flags; a set event in the same cycle beats a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      if (ovr_set)                            overrun <= 1'b1;
      else if (stat_wr && wr_data[STAT_OVR])  overrun <= 1'b0;
      if (ferr_set)                           ferr    <= 1'b1;
      else if (stat_wr && wr_data[STAT_FERR]) ferr    <= 1'b0;
    end
  end

  assign unused_bits = ^{wr_data[31:3], wr_data[STAT_NEMPTY], wr_be[3:1]};

endmodule

// File: tb/tb_user_uart_rx.sv
// Bench for user_uart_rx: drives 8N1 frames at a reduced bit period (16
// clocks) and checks bus reads against a queue-based model of the FIFO and
// flags. A compare process checks grants and held read data every cycle.
module tb_user_uart_rx;

  localparam int unsigned BAUD     = 115200;
  localparam int unsigned CLK_FREQ = 1_843_200;
  localparam int unsigned BC       = 16;
  localparam logic [31:0] A_DATA   = 32'h0003_0004;
  localparam logic [31:0] A_STAT   = 32'h0003_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        line;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  logic        m_ovr  = 1'b0;
  logic        m_ferr = 1'b0;
  logic [31:0] rd_hold = 32'h0;
  logic [31:0] rd_next_exp = 32'h0;

  user_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_uart_rx (line),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_gnt    (wr_gnt),
    .wr_addr   (wr_addr),
    .wr_be     (wr_be),
    .wr_data   (wr_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >= 32'h0003_0004) && (a <= 32'h0003_000B);
  endfunction

  function automatic logic [31:0] model_stat();
    logic [7:0] n;
    n = 8'(q.size());
    return {16'h0, n, 5'h0, m_ferr, m_ovr, q.size() != 0};
  endfunction

  // Compare process: quarter period after the driving edge.
  always begin
    @(negedge clk);
    #5;
    if (rst) rd_hold = 32'h0;
    check("rd_gnt", 32'(rd_gnt), 32'(rd_req && in_range(rd_addr)));
    check("wr_gnt", 32'(wr_gnt), 32'(wr_req && in_range(wr_addr)));
    check("rd_data_hold", rd_data, rd_hold);
    if (rd_req && in_range(rd_addr)) rd_hold = rd_next_exp;
  end

  // One 8N1 frame, LSB first; the model records what the receiver must do.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line = fr[i];
      repeat (BC) @(negedge clk);
    end
    if (!stop)               m_ferr = 1'b1;
    else if (q.size() == 16) m_ovr  = 1'b1;
    else                     q.push_back(b);
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] exp);
    exp = rd_hold;
    if (in_range(a)) begin
      if (a >= A_STAT)      exp = model_stat();
      else if (q.size() > 0) exp = {23'h0, 1'b1, q.pop_front()};
      else                  exp = 32'h0;
    end
    rd_next_exp = exp;
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_req  = 1'b0;
    rd_addr = 32'h0;
  endtask

  task automatic rd_lit(input logic [31:0] a, input logic [31:0] lit, input string nm);
    logic [31:0] e;
    rd(a, e);
    check({nm, "_model"}, e, lit);
    check(nm, rd_data, lit);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    if (in_range(a) && a >= A_STAT && be[0]) begin
      if (d[1]) m_ovr  = 1'b0;
      if (d[2]) m_ferr = 1'b0;
    end
    wr_req  = 1'b1;
    wr_addr = a;
    wr_be   = be;
    wr_data = d;
    @(negedge clk);
    wr_req  = 1'b0;
    wr_addr = 32'h0;
  endtask

  task automatic model_clear();
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [31:0] e;
    logic [31:0] addrs [6];
    logic [7:0]  b;
    logic        stop;
    addrs = '{A_DATA, A_STAT, 32'h0003_0005, 32'h0003_000B, 32'h0003_0000, 32'h0003_000C};

    rst = 1'b1; line = 1'b1;
    rd_req = 1'b0; rd_addr = 32'h0;
    wr_req = 1'b0; wr_addr = 32'h0; wr_be = 4'h0; wr_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    idle(2 * BC);

    // Single byte
    rd_lit(A_STAT, 32'h0, "stat_reset");
    send(8'h55, 1'b1); idle(4);
    rd_lit(A_STAT, 32'h0000_0101, "t1_stat");
    rd_lit(A_DATA, 32'h0000_0155, "t1_data");
    rd_lit(A_STAT, 32'h0, "t1_stat_after");

    // Back-to-back frames with one stop bit
    send(8'h00, 1'b1); send(8'hFF, 1'b1); send(8'hA5, 1'b1); idle(4);
    rd_lit(A_DATA, 32'h100, "t2_d0");
    rd_lit(A_DATA, 32'h1FF, "t2_d1");
    rd_lit(A_DATA, 32'h1A5, "t2_d2");
    rd_lit(A_DATA, 32'h0, "t2_empty");

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send(8'($urandom), 1'b1);
    idle(4);
    rd_lit(A_STAT, 32'h0000_1003, "t3_stat_full");
    for (int i = 0; i < 16; i++) rd(A_DATA, e);
    rd_lit(A_STAT, 32'h2, "t3_stat_drained");
    wr(A_STAT, 4'h1, 32'h2);
    rd_lit(A_STAT, 32'h0, "t3_ovr_cleared");

    // Framing error followed by a held-low line
    send(8'h3C, 1'b0);
    repeat (3 * BC) @(negedge clk);
    idle(BC);
    rd_lit(A_STAT, 32'h4, "t4_ferr");
    wr(A_STAT, 4'h0, 32'h4);
    wr(A_DATA, 4'hF, 32'hFFFF_FFFF);
    rd_lit(A_STAT, 32'h4, "t4_ferr_no_be");
    send(8'h3C, 1'b1); idle(4);
    rd_lit(A_DATA, 32'h13C, "t4_data");
    wr(A_STAT, 4'h1, 32'h4);
    rd_lit(A_STAT, 32'h0, "t4_ferr_cleared");

    // Short low glitch on an idle line
    line = 1'b0;
    repeat (7) @(negedge clk);
    idle(2 * BC);
    rd_lit(A_STAT, 32'h0, "t5_glitch");
    send(8'h81, 1'b1); idle(4);
    rd_lit(A_DATA, 32'h181, "t5_after_glitch");

    // Randomized frames, gaps, reads and writes
    for (int i = 0; i < 40; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send(b, stop);
      if (!stop) idle(2 * BC);
      else       idle(int'($urandom_range(0, 12)));
      for (int k = int'($urandom_range(0, 2)); k > 0; k--)
        rd(addrs[$urandom_range(0, 5)], e);
      if ($urandom_range(0, 5) == 0)
        wr(addrs[$urandom_range(0, 5)], 4'($urandom), 32'($urandom));
    end
    for (int i = 0; i < 17; i++) rd(A_DATA, e);
    wr(A_STAT, 4'h1, 32'h6);
    rd_lit(A_STAT, 32'h0, "rand_drained");

    // Reset during DATA bit 4 with two bytes queued
    send(8'h11, 1'b1); send(8'h22, 1'b1); idle(4);
    rd_lit(A_STAT, 32'h0000_0201, "t6_two_queued");
    line = 1'b0; repeat (BC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line = (i % 2 == 0); repeat (BC) @(negedge clk);
    end
    line = 1'b0;
    repeat (BC / 2) @(negedge clk);
    rst = 1'b1; line = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("t6_rd_data_in_reset", rd_data, 32'h0);
    rst = 1'b0;
    idle(2 * BC);
    rd_lit(A_STAT, 32'h0, "t6_stat");
    send(8'hC3, 1'b1); idle(4);
    rd_lit(A_DATA, 32'h1C3, "t6_data");
    rd_lit(A_DATA, 32'h0, "t6_empty");

    // Line already low when reset is released starts a frame
    rst = 1'b1; line = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h96, 1'b1); idle(4);
    rd_lit(A_DATA, 32'h196, "t7_low_at_release");

    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
